// File: rtl/bip_datapath_if.sv
// Control word from the instruction control unit to the accumulator datapath,
// plus the accumulator and status flags returned to it.
interface bip_datapath_if #(
    parameter int DATA_W = 16
);
    logic [1:0]        SelA;
    logic              SelB;
    logic              WrAcc;
    logic              Op;
    logic              WrRam;
    logic              RdRam;
    logic [10:0]       Operand;
    logic [DATA_W-1:0] acc;
    logic              flag_z;
    logic              flag_n;
    logic              flag_v;

    // Control unit side: issues the control word, observes the status.
    modport master (
        output SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
        input  acc, flag_z, flag_n, flag_v
    );

    // Datapath side: consumes the control word, reports the status.
    modport slave (
        input  SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
        output acc, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: operand select, add/sub ALU, accumulator with
// Z/N/V flags and a single-cycle data memory with a combinational debug port.
module bip_datapath #(
    parameter int DATA_W     = 16,
    parameter int RAM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    bip_datapath_if.slave         ctl,
    input  logic [RAM_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int DEPTH = 1 << RAM_ADDR_W;
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'b00,
        SRC_IMM  = 2'b01,
        SRC_ALU  = 2'b10,
        SRC_HOLD = 2'b11
    } acc_src_e;

    acc_src_e              acc_src;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     mem_rd;
    logic [DATA_W-1:0]     mem_op;
    logic [DATA_W-1:0]     alu_b;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_v;
    logic [DATA_W-1:0]     acc_q;
    logic [DATA_W-1:0]     acc_d;
    logic                  flag_v_q;
    logic                  flag_v_d;
    logic                  acc_we;

    logic [DATA_W-1:0] mem [DEPTH];

    assign acc_src  = acc_src_e'(ctl.SelA);
    assign ram_addr = ctl.Operand[RAM_ADDR_W-1:0];
    assign imm      = {{(DATA_W-11){ctl.Operand[10]}}, ctl.Operand};
    assign mem_rd   = mem[ram_addr];
    assign mem_op   = ctl.RdRam ? mem_rd : '0;
    assign alu_b    = ctl.SelB ? imm : mem_op;
    assign acc_we   = ctl.WrAcc && (acc_src != SRC_HOLD);

    // Overflow is judged on sign bits: for subtraction B's sign is effectively
    // inverted, so "same sign" for add becomes "different sign" for sub.
    always_comb begin
        alu_res = ctl.Op ? (acc_q - alu_b) : (acc_q + alu_b);
        alu_v   = ((acc_q[MSB] ^ alu_b[MSB]) == ctl.Op) && (alu_res[MSB] != acc_q[MSB]);
    end

    always_comb begin
        acc_d    = acc_q;
        flag_v_d = flag_v_q;
        if (acc_we) begin
            unique case (acc_src)
                SRC_MEM: begin
                    acc_d    = mem_op;
                    flag_v_d = 1'b0;
                end
                SRC_IMM: begin
                    acc_d    = imm;
                    flag_v_d = 1'b0;
                end
                SRC_ALU: begin
                    acc_d    = alu_res;
                    flag_v_d = alu_v;
                end
                default: begin
                    acc_d    = acc_q;
                    flag_v_d = flag_v_q;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // which is what lets a store and an accumulator load share one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            flag_v_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            flag_v_q <= flag_v_d;
        end
    end

    // NOTE: the memory array has no reset; clearing it would force flops in
    // place of RAM and reset must leave stored data intact.
    always_ff @(posedge clk) begin
        if (ctl.WrRam) begin
            mem[ram_addr] <= acc_q;
        end
    end

    // Z and N are pure functions of the accumulator, so they track it for free.
    assign ctl.acc    = acc_q;
    assign ctl.flag_z = (acc_q == '0);
    assign ctl.flag_n = acc_q[MSB];
    assign ctl.flag_v = flag_v_q;
    assign dbg_data   = mem[dbg_addr];
endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: a signed-integer reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_bip_datapath;
    localparam int DATA_W     = 16;
    localparam int RAM_ADDR_W = 10;
    localparam int DEPTH      = 1 << RAM_ADDR_W;

    logic                  clk;
    logic                  reset;
    logic [RAM_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    bip_datapath_if #(.DATA_W(DATA_W)) bus ();

    bip_datapath #(.DATA_W(DATA_W), .RAM_ADDR_W(RAM_ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctl      (bus.slave),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accumulator as a 16-bit word, ALU done in signed integers.
    logic [15:0] m_acc = 16'h0000;
    logic        m_v   = 1'b0;
    logic [15:0] m_mem [DEPTH];
    bit          m_ok  [DEPTH];
    logic [15:0] m_imm, m_memv, m_b, m_old;
    int          m_a, m_bi, m_r, m_addr;

    always @(negedge reset) begin
        m_acc = 16'h0000;
        m_v   = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_old  = m_acc;
            m_addr = int'(bus.Operand) % DEPTH;
            m_imm  = bus.Operand[10] ? (16'hF800 | 16'(bus.Operand)) : 16'(bus.Operand);
            m_memv = bus.RdRam ? (m_ok[m_addr] ? m_mem[m_addr] : 16'hxxxx) : 16'h0000;
            m_b    = bus.SelB ? m_imm : m_memv;
            m_a    = int'($signed(m_acc));
            m_bi   = int'($signed(m_b));
            m_r    = bus.Op ? (m_a - m_bi) : (m_a + m_bi);
            if (bus.WrAcc) begin
                case (bus.SelA)
                    2'd0: begin m_acc = m_memv; m_v = 1'b0; end
                    2'd1: begin m_acc = m_imm;  m_v = 1'b0; end
                    2'd2: begin m_acc = m_r[15:0]; m_v = (m_r > 32767) || (m_r < -32768); end
                    default: ;
                endcase
            end
            if (bus.WrRam) begin
                m_mem[m_addr] = m_old;
                m_ok[m_addr]  = 1'b1;
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        check("acc", 32'(bus.acc), 32'(m_acc));
        check("flag_z", 32'(bus.flag_z), 32'(m_acc == 16'h0000));
        check("flag_n", 32'(bus.flag_n), 32'(m_acc >= 16'h8000));
        check("flag_v", 32'(bus.flag_v), 32'(m_v));
        if (m_ok[dbg_addr]) check("dbg_data", 32'(dbg_data), 32'(m_mem[dbg_addr]));
    end

    task automatic drive(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                         input logic wr, input logic rd, input logic [10:0] opnd);
        bus.SelA = sa; bus.SelB = sb; bus.WrAcc = wa; bus.Op = op;
        bus.WrRam = wr; bus.RdRam = rd; bus.Operand = opnd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    endtask

    task automatic cyc(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                       input logic wr, input logic rd, input logic [10:0] opnd);
        drive(sa, sb, wa, op, wr, rd, opnd);
        tick();
    endtask

    // acc <- 2*acc (+1 when inc) through mem[9]
    task automatic dbl(input logic inc);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd9);
        cyc(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd9);
        if (inc) cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
    endtask

    initial begin
        reset    = 1'b1;
        dbg_addr = '0;
        drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'b0, 1'($urandom), 11'($urandom));
        #1 reset = 1'b0;
        #2;
        check("reset_acc", 32'(bus.acc), 32'h0000);
        check("reset_z", 32'(bus.flag_z), 32'h1);
        check("reset_n", 32'(bus.flag_n), 32'h0);
        check("reset_v", 32'(bus.flag_v), 32'h0);
        @(posedge clk);
        #1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
        reset = 1'b1;

        // Load immediate and store
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF);
        check("ldi_3ff", 32'(bus.acc), 32'h03FF);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd5);
        dbg_addr = 10'd5;
        #1 check("store_5", 32'(dbg_data), 32'h03FF);
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h400);
        check("ldi_400", 32'(bus.acc), 32'hFC00);
        check("ldi_400_n", 32'(bus.flag_n), 32'h1);

        // Memory add / subtract
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
        cyc(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd5);
        check("add_mem", 32'(bus.acc), 32'h0400);
        cyc(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd5);
        check("sub_mem", 32'(bus.acc), 32'h0001);
        cyc(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5);
        check("add_rd0", 32'(bus.acc), 32'h0001);

        // Overflow and wrap: build 0x7FFF from 0x3FF by x -> 2x+1
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h3FF);
        for (int i = 0; i < 5; i++) dbl(1'b1);
        check("build_7fff", 32'(bus.acc), 32'h7FFF);
        cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
        check("ovf_acc", 32'(bus.acc), 32'h8000);
        check("ovf_v", 32'(bus.flag_v), 32'h1);
        check("ovf_n", 32'(bus.flag_n), 32'h1);
        cyc(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF);
        check("sub_m1", 32'(bus.acc), 32'h8001);
        check("sub_m1_v", 32'(bus.flag_v), 32'h0);
        cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF);
        cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF);
        check("neg_ovf_v", 32'(bus.flag_v), 32'h1);
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
        check("ldi_clr_v", 32'(bus.flag_v), 32'h0);
        cyc(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1);
        check("sub_zero", 32'(bus.acc), 32'h0000);
        check("sub_zero_z", 32'(bus.flag_z), 32'h1);

        // Simultaneous store and load: build 0x1234 from 0x246
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h246);
        dbl(1'b1);
        dbl(1'b0);
        dbl(1'b0);
        check("build_1234", 32'(bus.acc), 32'h1234);
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd7);
        check("st_ld_acc", 32'(bus.acc), 32'h0007);
        dbg_addr = 10'd7;
        #1 check("st_ld_mem", 32'(dbg_data), 32'h1234);
        cyc(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd7);
        check("ld_mem7", 32'(bus.acc), 32'h1234);

        // Address wrap, read-during-write, hold
        dbg_addr = 10'd5;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h405);
        #1 check("wr_cycle_old", 32'(dbg_data), 32'h03FF);
        tick();
        check("wrap_405", 32'(dbg_data), 32'h1234);
        cyc(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 11'h123);
        check("hold_acc", 32'(bus.acc), 32'h1234);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h055);
        check("wracc0_acc", 32'(bus.acc), 32'h1234);

        // Mid-sequence reset pulse, away from the clock edge
        #2 reset = 1'b0;
        #1;
        check("rst2_acc", 32'(bus.acc), 32'h0000);
        check("rst2_z", 32'(bus.flag_z), 32'h1);
        check("rst2_mem5", 32'(dbg_data), 32'h1234);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h055);
        check("post_rst_ld", 32'(bus.acc), 32'h0055);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bip_datapath.md
# bip_datapath

Accumulator datapath for the BIP-style processor. It executes the control word produced each cycle by the instruction control unit: operand selection, add/subtract, accumulator write, data-memory read/write. It owns the 16-bit accumulator, the data memory array and the status flags. It sits directly beside the control unit, with its ports wired one-to-one to the control outputs.

## Interface
- DATA_W, 16: accumulator, ALU and data-memory word width.
- RAM_ADDR_W, 10: data-memory address width. Depth is 2^RAM_ADDR_W words. Must be ≤ 11.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- SelA  in  2  accumulator source: 00 data memory, 01 immediate, 10 ALU result, 11 hold.
- SelB  in  1  ALU operand B: 0 data memory, 1 immediate.
- WrAcc  in  1  accumulator write enable.
- Op  in  1  ALU operation: 0 add (A+B), 1 subtract (A−B); A is always the accumulator.
- WrRam  in  1  write accumulator to data memory at Operand.
- RdRam  in  1  data-memory read enable.
- Operand  in  11  immediate value / data-memory address.
- dbg_addr  in  RAM_ADDR_W  debug read address.
- acc  out  DATA_W  current accumulator value.
- flag_z  out  1  accumulator zero.
- flag_n  out  1  accumulator negative (MSB).
- flag_v  out  1  signed overflow of the last ALU write.
- dbg_data  out  DATA_W  combinational data-memory contents at dbg_addr.

## Operation
- Immediate: Operand sign-extended from 11 to DATA_W bits (bit 10 replicated).
- Memory address: Operand[RAM_ADDR_W-1:0]. Upper Operand bits are ignored; addresses wrap modulo the depth.
- Memory read value is combinational from the array. The memory-sourced operand is forced to 0 when RdRam=0.
- ALU: result = acc ± B, truncated to DATA_W. Wrap-around is modulo 2^DATA_W.
- Signed overflow V:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from acc.
- Accumulator update on the rising edge when WrAcc=1 and SelA≠11:
  - acc ← selected source.
  - flag_z and flag_n recomputed from the new value.
  - flag_v ← V when SelA=10; cleared to 0 when SelA=00 or 01.
- WrAcc=0 or SelA=11: acc and all flags hold.
- Memory write on the rising edge when WrRam=1: mem[addr] ← acc, using the pre-edge value.
- WrRam and WrAcc in the same cycle: memory stores the old acc and acc takes its new value. Both happen on the same edge.
- Read-after-write to the same address: the write lands at the edge, and the read in the next cycle returns the new data. Within the write cycle the read returns the old data.
- Data memory is not cleared by reset.
- Reset values:
  - acc = 0
  - flag_z = 1, flag_n = 0, flag_v = 0
  - dbg_data reflects unreset memory contents.

## Timing
- Single-cycle execution: control inputs are sampled at edge k and results are visible on acc/flags after edge k.
- No handshake. Every cycle's control word is consumed; an all-zero control word is a no-op.
- Combinational path: Operand / RdRam / SelB → ALU → acc D-input within one cycle.
- Latency:
  - acc, flags and memory contents: 1 cycle.
  - dbg_data: 0 cycles, combinational.
- Reset assertion mid-operation clears acc and flags immediately (asynchronously).
- A memory write coincident with reset assertion is not guaranteed.
- After reset release, the first edge executes normally.

## Test plan
- Reset: drive control inputs to random values and assert reset → acc=0x0000, flag_z=1, flag_n=0, flag_v=0, with no clock edge needed.
- Load immediate and store: SelA=01, WrAcc=1, Operand=0x3FF → acc=0x03FF. Then WrRam=1, Operand=5 → dbg_addr=5 shows 0x03FF. A second load with Operand=0x400 → acc=0xFC00, flag_n=1.
- Memory add/subtract:
  - Setup: mem[5]=0x03FF, acc=0x0001.
  - SelA=10, SelB=0, RdRam=1, Op=0 → acc=0x0400.
  - Then Op=1 → acc=0x0001.
  - With RdRam=0, Op=0 → acc unchanged, since the operand is 0.
- Overflow and wrap:
  - acc=0x7FFF, immediate +1 add → acc=0x8000, flag_v=1, flag_n=1.
  - Then immediate −1 (Operand=0x7FF) sub → acc=0x8001, flag_v=0.
  - acc=0x0001 minus immediate 1 → acc=0x0000, flag_z=1.
- Simultaneous store and load: acc=0x1234, WrRam=1, WrAcc=1, SelA=01, Operand=7 → mem[7]=0x1234, acc=0x0007. Next cycle, SelA=00, RdRam=1, Operand=7 → acc=0x1234.
- Address wrap and hold:
  - Store to Operand=0x405 with RAM_ADDR_W=10 → the value appears at dbg_addr=5.
  - SelA=11, WrAcc=1 → acc and flags unchanged.
  - Reset pulse mid-sequence → acc cleared, mem[5] retained.
